// File: rtl/kaleido_pkg.sv
// rtl/kaleido_pkg.sv - shared constants and palette mapping for the kaleidoscope pixel source
package kaleido_pkg;

    localparam int COLOR_W      = 8;
    localparam int H_CENTER_DEF = 320;
    localparam int V_CENTER_DEF = 240;

    // Green channel is tinted by the top frame bits so slow colour cycling rides on top of the fast value shift
    function automatic logic [COLOR_W-1:0] kaleido_palette(input logic [7:0] v, input logic [7:0] frame);
        return {v[7:5], v[4:2] ^ frame[7:5], v[1:0]};
    endfunction

endpackage

// File: rtl/kaleido_fold.sv
// rtl/kaleido_fold.sv - combinational mirror distance of a coordinate about a center line
module kaleido_fold #(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 9,
    parameter int CENTER = 320
) (
    input  logic [IN_W-1:0]  pos_i,
    output logic [OUT_W-1:0] dist_o
);

    // Left/top side uses CENTER-1-pos so pixel p and its mirror 2*CENTER-1-p land on the same distance
    assign dist_o = OUT_W'((pos_i >= IN_W'(CENTER)) ? (pos_i - IN_W'(CENTER))
                                                     : (IN_W'(CENTER - 1) - pos_i));

endmodule

// File: rtl/kaleido_pattern_gen.sv
// rtl/kaleido_pattern_gen.sv - 4-stage kaleidoscope pixel pipeline with per-frame animation counter
module kaleido_pattern_gen
    import kaleido_pkg::*;
#(
    parameter int H_CENTER = H_CENTER_DEF,
    parameter int V_CENTER = V_CENTER_DEF
) (
    input  logic               CLK_25MHz,
    input  logic               RESET,
    input  logic [9:0]         CURX,
    input  logic [8:0]         CURY,
    input  logic               BLANK,
    input  logic               VBLANK,
    input  logic               PAUSE,
    output logic [COLOR_W-1:0] COLOR_DATA_OUT,
    output logic [7:0]         FRAME
);

    logic [8:0]         dx_d, dx_q;
    logic [7:0]         dy_d, dy_q;
    logic [8:0]         a_d, a_q;
    logic [7:0]         b_d, b_q;
    logic [7:0]         v_q;
    logic [COLOR_W-1:0] color_q;
    logic [3:0]         blank_q;
    logic [7:0]         frame_q;
    logic               vb_prev_q;

    kaleido_fold #(.IN_W(10), .OUT_W(9), .CENTER(H_CENTER)) u_fold_x (
        .pos_i  (CURX),
        .dist_o (dx_d)
    );

    kaleido_fold #(.IN_W(9), .OUT_W(8), .CENTER(V_CENTER)) u_fold_y (
        .pos_i  (CURY),
        .dist_o (dy_d)
    );

    // When dx > dy the smaller value is dy; otherwise dx <= dy < 256 so its low byte is exact
    always_comb begin
        a_d = {1'b0, dy_q};
        b_d = dx_q[7:0];
        if (dx_q >= {1'b0, dy_q}) begin
            a_d = dx_q;
            b_d = dy_q;
        end
    end

    always_ff @(posedge CLK_25MHz or posedge RESET) begin
        if (RESET) begin
            dx_q      <= '0;
            dy_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            v_q       <= '0;
            color_q   <= '0;
            blank_q   <= '1;
            frame_q   <= '0;
            vb_prev_q <= 1'b1;
        end else begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            a_q       <= a_d;
            b_q       <= b_d;
            v_q       <= (a_q[8:1] ^ b_q) + frame_q;
            color_q   <= kaleido_palette(v_q, frame_q);
            blank_q   <= {blank_q[2:0], BLANK};
            vb_prev_q <= VBLANK;
            if (VBLANK && !vb_prev_q && !PAUSE) begin
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    assign COLOR_DATA_OUT = blank_q[3] ? '0 : color_q;
    assign FRAME          = frame_q;

endmodule

// File: tb/tb_kaleido_pattern_gen.sv
// tb/tb_kaleido_pattern_gen.sv - directed self-checking bench for kaleido_pattern_gen
`timescale 1ns/1ps
module tb_kaleido_pattern_gen;

    logic       clk;
    logic       rst;
    logic [9:0] curx;
    logic [8:0] cury;
    logic       blank;
    logic       vblank;
    logic       pause;
    logic [7:0] color;
    logic [7:0] frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] img [0:479][0:639];
    int         qx[$];
    int         qy[$];

    kaleido_pattern_gen dut (
        .CLK_25MHz      (clk),
        .RESET          (rst),
        .CURX           (curx),
        .CURY           (cury),
        .BLANK          (blank),
        .VBLANK         (vblank),
        .PAUSE          (pause),
        .COLOR_DATA_OUT (color),
        .FRAME          (frame)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic b);
        curx  = 10'(x);
        cury  = 9'(y);
        blank = b;
    endtask

    task automatic pix(input int x, input int y, output logic [7:0] c);
        drive(x, y, 1'b0);
        repeat (4) tick();
        c = color;
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick();
        tick();
        vblank = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [7:0] model(input int x, input int y, input int f);
        int dx, dy, a, b;
        logic [7:0] v, ff;
        dx = (x >= 320) ? x - 320 : 319 - x;
        dy = (y >= 240) ? y - 240 : 239 - y;
        a  = (dx > dy) ? dx : dy;
        b  = (dx > dy) ? dy : dx;
        ff = 8'(f);
        v  = 8'(((a >> 1) ^ b) + f);
        return {v[7:5], v[4:2] ^ ff[7:5], v[1:0]};
    endfunction

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int sym_err, mod_err, y;

        rst = 1'b1; vblank = 1'b0; pause = 1'b0;
        drive(0, 0, 1'b1);
        repeat (3) tick();
        check_eq("reset_color", color, 8'h00);
        check_eq("reset_frame", frame, 8'h00);
        rst = 1'b0;

        // basic pixel latency, then the following pixel
        drive(330, 240, 1'b0);
        tick();
        drive(0, 0, 1'b0);
        tick(); tick();
        check_eq("latency_edge3", color, 8'h00);
        tick();
        check_eq("basic_330_240", color, 8'h05);
        tick();
        check_eq("next_0_0", color, 8'h70);

        pix(309, 240, c); check_eq("sym_309_240", c, 8'h05);
        pix(320, 250, c); check_eq("sym_320_250", c, 8'h05);
        pix(320, 229, c); check_eq("sym_320_229", c, 8'h05);

        // single blanked pixel in a run
        for (int i = 0; i < 16; i++) begin
            if (i >= 4) check_eq($sformatf("blank_run%0d", i - 4), color, (i - 4 == 5) ? 8'h00 : 8'h05);
            if (i < 12) drive(330, 240, i == 5);
            tick();
        end

        // vblank edge and pause rise together: pause wins
        vblank = 1'b1; pause = 1'b1;
        tick(); tick();
        check_eq("pause_wins", frame, 8'h00);
        vblank = 1'b0; pause = 1'b0;
        tick(); tick();

        repeat (3) vb_pulse();
        check_eq("frame_3", frame, 8'd3);
        pix(330, 240, c); check_eq("frame3_pixel", c, 8'h08);

        sym_err = 0; mod_err = 0;
        for (int k = 0; k < 30; k++) begin
            for (int r = 0; r < 2; r++) begin
                y = (r == 1) ? 479 - 8 * k : 8 * k;
                for (int x = 0; x < 640; x++) begin
                    if (qx.size() == 4) img[qy.pop_front()][qx.pop_front()] = color;
                    drive(x, y, 1'b0);
                    qx.push_back(x);
                    qy.push_back(y);
                    tick();
                end
            end
        end
        while (qx.size() > 0) begin
            img[qy.pop_front()][qx.pop_front()] = color;
            tick();
        end
        for (int k = 0; k < 30; k++) begin
            for (int x = 0; x < 640; x++) begin
                if (img[8 * k][x] !== img[8 * k][639 - x]) sym_err++;
                if (img[8 * k][x] !== img[479 - 8 * k][x]) sym_err++;
                if (img[8 * k][x] !== model(x, 8 * k, 3)) mod_err++;
                if (img[479 - 8 * k][x] !== model(x, 479 - 8 * k, 3)) mod_err++;
            end
        end
        check_eq("sweep_symmetry_errs", sym_err, 0);
        check_eq("sweep_model_errs", mod_err, 0);

        repeat (252) vb_pulse();
        check_eq("frame_255", frame, 8'd255);
        pix(330, 240, c); check_eq("frame255_pixel", c, 8'h18);
        vb_pulse();
        check_eq("frame_wrap", frame, 8'd0);

        pause = 1'b1;
        repeat (5) vb_pulse();
        check_eq("paused_frame", frame, 8'd0);
        pause = 1'b0;
        vb_pulse();
        check_eq("unpause_inc", frame, 8'd1);

        repeat (5) vb_pulse();
        drive(330, 240, 1'b0);
        vblank = 1'b1;
        repeat (5) tick();
        check_eq("pre_reset_frame", frame, 8'd7);
        check_eq("pre_reset_color", color, 8'h0C);

        rst = 1'b1;
        #1;
        check_eq("async_reset_color", color, 8'h00);
        check_eq("async_reset_frame", frame, 8'h00);
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        check_eq("post_reset_edge3", color, 8'h00);
        tick();
        check_eq("post_reset_edge4", color, 8'h05);
        tick(); tick();
        check_eq("vblank_held_no_count", frame, 8'd0);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick(); tick();
        check_eq("post_reset_first_edge", frame, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
